// File: rtl/ups_rst_seq.sv
// Staged reset sequencer: power-on reset, then ordered, staggered release of NUM_CH
// reset domains, with per-channel re-reset that re-runs the release from that channel.
module ups_rst_seq #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 8,
    parameter int POR_CYCLES     = 255,
    parameter int HOLD_CYCLES    = 255,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] rst_req,
    output logic              por_n,
    output logic [NUM_CH-1:0] rst_n,
    output logic              seq_busy,
    output logic              seq_done,
    output logic [1:0]        seq_state
);

    localparam int IDX_W = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_POR     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    // In HOLD, idx is the channel being held; in RELEASE, the next channel to release.
    logic [IDX_W-1:0]  idx;

    logic [IDX_W-1:0]  req_ch;
    logic [IDX_W-1:0]  held_ch;
    logic [IDX_W-1:0]  new_start;
    logic [NUM_CH-1:0] keep_mask;
    logic [NUM_CH-1:0] rel_mask;

    // A request restarts from the lower of the requested channel and the lowest
    // channel still in reset, so the thermometer shape of rst_n is preserved.
    always_comb begin
        req_ch    = IDX_W'(NUM_CH);
        held_ch   = IDX_W'(NUM_CH);
        keep_mask = '0;
        rel_mask  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rst_req[i]) req_ch = IDX_W'(i);
            if (!rst_n[i])  held_ch = IDX_W'(i);
        end
        new_start = (req_ch < held_ch) ? req_ch : held_ch;
        for (int i = 0; i < NUM_CH; i++) begin
            keep_mask[i] = (IDX_W'(i) < new_start);
            rel_mask[i]  = (IDX_W'(i) == idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_POR;
            cnt      <= '0;
            idx      <= '0;
            por_n    <= 1'b0;
            rst_n    <= '0;
            seq_done <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            if (state != ST_POR && (|rst_req)) begin
                rst_n <= rst_n & keep_mask;
                cnt   <= '0;
                idx   <= new_start;
                state <= ST_HOLD;
            end else begin
                case (state)
                    ST_POR: begin
                        if (cnt == POR_LAST) begin
                            por_n <= 1'b1;
                            cnt   <= '0;
                            idx   <= '0;
                            state <= ST_HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            rst_n <= rst_n | rel_mask;
                            cnt   <= '0;
                            if (idx == LAST_CH) begin
                                seq_done <= 1'b1;
                                state    <= ST_RUN;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= ST_RELEASE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt == STAG_LAST) begin
                            rst_n <= rst_n | rel_mask;
                            cnt   <= '0;
                            if (idx == LAST_CH) begin
                                seq_done <= 1'b1;
                                state    <= ST_RUN;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign seq_busy  = ~por_n | ~(&rst_n);
    assign seq_state = state;

endmodule

// File: tb/tb_ups_rst_seq.sv
// Directed bench for ups_rst_seq: vector table for boot and re-reset timing, plus
// hand-written reset-mid-release and request-during-POR sequences.
module tb_ups_rst_seq;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int POR_C  = 8;
    localparam int HOLD_C = 4;
    localparam int STAG_C = 2;
    localparam int DONE_N = POR_C + HOLD_C + (NUM_CH - 1) * STAG_C;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] rst_req = '0;
    logic              por_n;
    logic [NUM_CH-1:0] rst_n;
    logic              seq_busy;
    logic              seq_done;
    logic [1:0]        seq_state;

    always #5 clk = ~clk;

    ups_rst_seq #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .POR_CYCLES(POR_C),
        .HOLD_CYCLES(HOLD_C), .STAGGER_CYCLES(STAG_C)
    ) dut (
        .clk(clk), .rst(rst), .rst_req(rst_req), .por_n(por_n), .rst_n(rst_n),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_state(seq_state)
    );

    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;
    logic prev_done = 1'b0;

    typedef struct {
        logic              rst;
        logic [NUM_CH-1:0] req;
        logic              por_n;
        logic [NUM_CH-1:0] rst_n;
        logic              done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic r, input logic [NUM_CH-1:0] q, input logic p,
                                    input logic [NUM_CH-1:0] n, input logic d);
        vec_t v;
        v.rst = r; v.req = q; v.por_n = p; v.rst_n = n; v.done = d;
        vecs.push_back(v);
    endfunction

    // Reset cycles followed by nrun clean edges; channel c rises POR+HOLD+c*STAGGER edges in.
    function automatic void add_boot(input int nrst, input int nrun, input logic [NUM_CH-1:0] por_req);
        logic [NUM_CH-1:0] rn;
        for (int i = 0; i < nrst; i++) add_vec(1'b1, por_req, 1'b0, '0, 1'b0);
        for (int n = 1; n <= nrun; n++) begin
            for (int c = 0; c < NUM_CH; c++) rn[c] = (n >= POR_C + HOLD_C + c * STAG_C);
            add_vec(1'b0, (n <= POR_C) ? por_req : '0, (n >= POR_C), rn, (n == DONE_N));
        end
    endfunction

    function automatic logic therm_ok(input logic p, input logic [NUM_CH-1:0] n);
        logic ok;
        ok = 1'b1;
        for (int i = 1; i < NUM_CH; i++) if (n[i] && !n[i-1]) ok = 1'b0;
        if ((|n) && !p) ok = 1'b0;
        return ok;
    endfunction

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("thermometer", therm_ok(por_n, rst_n), 1);
            check("done_width", seq_done && prev_done, 0);
            prev_done = seq_done;
        end
    end

    task automatic apply_vec(input vec_t v, input int k);
        rst = v.rst;
        rst_req = v.req;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d por_n", k), por_n, v.por_n);
        check($sformatf("vec%0d rst_n", k), rst_n, v.rst_n);
        check($sformatf("vec%0d seq_busy", k), seq_busy, (!v.por_n) || (v.rst_n != '1));
        check($sformatf("vec%0d seq_done", k), seq_done, v.done);
        @(negedge clk);
    endtask

    // Reset (with a request that must lose to rst), then time every release edge.
    task automatic boot_seq(input string name, input logic [NUM_CH-1:0] por_req, input int nrst);
        int n;
        int por_at;
        int done_at;
        int rel_at[NUM_CH];
        rst = 1'b1;
        rst_req = 4'b0100;
        for (int i = 0; i < nrst; i++) begin
            @(posedge clk);
            #1;
            check({name, " rst por_n"}, por_n, 0);
            check({name, " rst rst_n"}, rst_n, 0);
            check({name, " rst busy"}, seq_busy, 1);
            check({name, " rst done"}, seq_done, 0);
            check({name, " rst state"}, seq_state, 0);
            @(negedge clk);
        end
        rst = 1'b0;
        n = 0;
        por_at = -1;
        done_at = -1;
        for (int c = 0; c < NUM_CH; c++) rel_at[c] = -1;
        while (done_at < 0 && n < 60) begin
            rst_req = (n + 1 == 2 || n + 1 == 5 || n + 1 == 8) ? por_req : '0;
            @(posedge clk);
            #1;
            n++;
            if (por_n && por_at < 0) por_at = n;
            for (int c = 0; c < NUM_CH; c++) if (rst_n[c] && rel_at[c] < 0) rel_at[c] = n;
            if (seq_done) done_at = n;
            @(negedge clk);
        end
        rst_req = '0;
        check({name, " done_at"}, done_at, DONE_N);
        check({name, " por_at"}, por_at, POR_C);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("%s rel_at[%0d]", name, c), rel_at[c], POR_C + HOLD_C + c * STAG_C);
    endtask

    initial begin
        @(negedge clk);

        // Boot with 3 reset cycles, then run past the last release.
        add_boot(3, 20, '0);
        // Re-reset of channel 2 from RUN.
        add_vec(0, 4'b0100, 1, 4'b0011, 0);
        for (int i = 0; i < 3; i++) add_vec(0, '0, 1, 4'b0011, 0);
        add_vec(0, '0, 1, 4'b0111, 0);
        add_vec(0, '0, 1, 4'b0111, 0);
        add_vec(0, '0, 1, 4'b1111, 1);
        add_vec(0, '0, 1, 4'b1111, 0);
        // Channel 3, then channel 1 two cycles later: hold restarts from the second.
        add_vec(0, 4'b1000, 1, 4'b0111, 0);
        add_vec(0, '0, 1, 4'b0111, 0);
        add_vec(0, 4'b0010, 1, 4'b0001, 0);
        for (int i = 0; i < 3; i++) add_vec(0, '0, 1, 4'b0001, 0);
        add_vec(0, '0, 1, 4'b0011, 0);
        add_vec(0, '0, 1, 4'b0011, 0);
        add_vec(0, '0, 1, 4'b0111, 0);
        add_vec(0, '0, 1, 4'b0111, 0);
        add_vec(0, '0, 1, 4'b1111, 1);
        add_vec(0, '0, 1, 4'b1111, 0);
        // Multi-bit request decodes to the lowest set bit.
        add_vec(0, 4'b1010, 1, 4'b0001, 0);
        for (int i = 0; i < 3; i++) add_vec(0, '0, 1, 4'b0001, 0);
        add_vec(0, '0, 1, 4'b0011, 0);
        add_vec(0, '0, 1, 4'b0011, 0);
        add_vec(0, '0, 1, 4'b0111, 0);
        add_vec(0, '0, 1, 4'b0111, 0);
        add_vec(0, '0, 1, 4'b1111, 1);
        add_vec(0, '0, 1, 4'b1111, 0);
        // Channel 0 re-reset; a higher request during RELEASE re-holds the lowest held channel.
        add_vec(0, 4'b0001, 1, 4'b0000, 0);
        for (int i = 0; i < 3; i++) add_vec(0, '0, 1, 4'b0000, 0);
        add_vec(0, '0, 1, 4'b0001, 0);
        add_vec(0, '0, 1, 4'b0001, 0);
        add_vec(0, '0, 1, 4'b0011, 0);
        add_vec(0, 4'b1000, 1, 4'b0011, 0);
        for (int i = 0; i < 3; i++) add_vec(0, '0, 1, 4'b0011, 0);
        add_vec(0, '0, 1, 4'b0111, 0);
        add_vec(0, '0, 1, 4'b0111, 0);
        add_vec(0, '0, 1, 4'b1111, 1);
        add_vec(0, '0, 1, 4'b1111, 0);
        // Partial boot that stops with channels 0..1 released (idx=2 in RELEASE).
        add_boot(1, POR_C + HOLD_C + STAG_C, '0);

        for (int k = 0; k < vecs.size(); k++) begin
            apply_vec(vecs[k], k);
            if (k == 0) mon_en = 1'b1;
        end

        // rst mid-release must restart the full timing.
        boot_seq("rst_mid_release", '0, 1);
        // Requests during POR are ignored.
        boot_seq("req_during_por", 4'b0001, 2);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
